// File: rtl/register_file_wb_if.sv
// Register file bus: two operand read ports, one writeback commit port,
// a debug read port, and the commit counter.
interface register_file_wb_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int CNT_WIDTH  = 16
);
    logic [ADDR_WIDTH-1:0] ReadRegister1;
    logic [ADDR_WIDTH-1:0] ReadRegister2;
    logic [ADDR_WIDTH-1:0] WriteRegister;
    logic [DATA_WIDTH-1:0] WriteData;
    logic                  RegWrite;
    logic [ADDR_WIDTH-1:0] DebugRegister;
    logic [DATA_WIDTH-1:0] ReadData1;
    logic [DATA_WIDTH-1:0] ReadData2;
    logic [DATA_WIDTH-1:0] DebugData;
    logic [CNT_WIDTH-1:0]  WriteCount;

    modport master (
        output ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, DebugRegister,
        input  ReadData1, ReadData2, DebugData, WriteCount
    );

    modport slave (
        input  ReadRegister1, ReadRegister2, WriteRegister, WriteData, RegWrite, DebugRegister,
        output ReadData1, ReadData2, DebugData, WriteCount
    );
endinterface

// File: rtl/register_file_wb.sv
// MIPS architectural register file: $0 hardwired to zero, optional write-first
// bypass on the operand ports, unbypassed debug port, saturating commit counter.
module register_file_wb #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int BYPASS     = 1,
    parameter int CNT_WIDTH  = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    register_file_wb_if.slave bus
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [CNT_WIDTH-1:0]  count;
    logic                  commit;

    always_comb begin
        commit = bus.RegWrite && (bus.WriteRegister != '0);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            count <= '0;
        end else if (commit) begin
            regs[bus.WriteRegister] <= bus.WriteData;
            if (count != '1) begin
                count <= count + 1'b1;
            end
        end
    end

    function automatic logic [DATA_WIDTH-1:0] port_read(input logic [ADDR_WIDTH-1:0] idx);
        if (idx == '0) begin
            return '0;
        end else if ((BYPASS != 0) && commit && (idx == bus.WriteRegister)) begin
            return bus.WriteData;
        end else begin
            return regs[idx];
        end
    endfunction

    // Outputs are forced to zero during reset so the bypass path cannot leak WriteData.
    always_comb begin
        bus.ReadData1  = '0;
        bus.ReadData2  = '0;
        bus.DebugData  = '0;
        bus.WriteCount = '0;
        if (Reset) begin
            bus.ReadData1  = port_read(bus.ReadRegister1);
            bus.ReadData2  = port_read(bus.ReadRegister2);
            bus.DebugData  = regs[bus.DebugRegister];
            bus.WriteCount = count;
        end
    end
endmodule

// File: tb/tb_register_file_wb.sv
// Self-checking bench: a bypassing 16-bit-counter instance and a non-bypassing
// 2-bit-counter instance see identical stimulus and are compared to one array model.
module tb_register_file_wb;
    logic Clk = 1'b0;
    logic Reset;
    always #5 Clk = ~Clk;

    register_file_wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(16)) bus_a ();
    register_file_wb_if #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .CNT_WIDTH(2))  bus_b ();

    register_file_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(1), .CNT_WIDTH(16)) dut_a (
        .Clk(Clk), .Reset(Reset), .bus(bus_a.slave)
    );
    register_file_wb #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .BYPASS(0), .CNT_WIDTH(2)) dut_b (
        .Clk(Clk), .Reset(Reset), .bus(bus_b.slave)
    );

    assign bus_b.ReadRegister1 = bus_a.ReadRegister1;
    assign bus_b.ReadRegister2 = bus_a.ReadRegister2;
    assign bus_b.WriteRegister = bus_a.WriteRegister;
    assign bus_b.WriteData     = bus_a.WriteData;
    assign bus_b.RegWrite      = bus_a.RegWrite;
    assign bus_b.DebugRegister = bus_a.DebugRegister;

    int unsigned total = 0;
    int unsigned bad   = 0;

    // Reference: architectural state as a plain array plus commit tallies.
    logic [31:0] model [32];
    int unsigned cnt_a, cnt_b;

    always @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++) model[i] = 32'd0;
            cnt_a = 0;
            cnt_b = 0;
        end else if (bus_a.RegWrite && bus_a.WriteRegister != 5'd0) begin
            model[bus_a.WriteRegister] = bus_a.WriteData;
            cnt_a = (cnt_a < 65535) ? cnt_a + 1 : 65535;
            cnt_b = (cnt_b < 3) ? cnt_b + 1 : 3;
        end
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] idx, input bit byp);
        if (!Reset || idx == 5'd0) return 32'd0;
        if (byp && bus_a.RegWrite && bus_a.WriteRegister == idx) return bus_a.WriteData;
        return model[idx];
    endfunction

    task automatic set_in(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                          input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] dbg);
        bus_a.RegWrite      = we;
        bus_a.WriteRegister = wa;
        bus_a.WriteData     = wd;
        bus_a.ReadRegister1 = r1;
        bus_a.ReadRegister2 = r2;
        bus_a.DebugRegister = dbg;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        Reset = 1'b1;
        for (int i = 0; i < 32; i++) begin
            set_in(1'b0, 5'd0, 32'd0, 5'(i), 5'(31 - i), 5'(i));
            #1;
            total++;
            if (bus_a.ReadData1 !== 32'd0 || bus_a.ReadData2 !== 32'd0 || bus_a.DebugData !== 32'd0 ||
                bus_b.ReadData1 !== 32'd0 || bus_b.ReadData2 !== 32'd0 || bus_b.DebugData !== 32'd0) begin
                bad++;
                $display("FAIL reset_read idx=%0d got a=%h/%h/%h b=%h/%h/%h expected all 0", i,
                         bus_a.ReadData1, bus_a.ReadData2, bus_a.DebugData,
                         bus_b.ReadData1, bus_b.ReadData2, bus_b.DebugData);
            end
        end
        total++;
        if (bus_a.WriteCount !== 16'd0 || bus_b.WriteCount !== 2'd0) begin
            bad++;
            $display("FAIL reset_count got a=%0d b=%0d expected 0", bus_a.WriteCount, bus_b.WriteCount);
        end
    endtask

    task automatic test_write_read();
        @(negedge Clk);
        set_in(1'b1, 5'd8, 32'hDEADBEEF, 5'd8, 5'd8, 5'd8);
        #1;
        total++;
        if (bus_a.ReadData1 !== 32'hDEADBEEF || bus_b.ReadData1 !== 32'd0 || bus_a.DebugData !== 32'd0) begin
            bad++;
            $display("FAIL pre_edge_8 got a=%h b=%h dbg=%h expected deadbeef/0/0",
                     bus_a.ReadData1, bus_b.ReadData1, bus_a.DebugData);
        end
        @(negedge Clk);
        set_in(1'b0, 5'd0, 32'd0, 5'd8, 5'd0, 5'd8);
        #1;
        total++;
        if (bus_a.ReadData1 !== 32'hDEADBEEF || bus_b.ReadData1 !== 32'hDEADBEEF ||
            bus_a.DebugData !== 32'hDEADBEEF) begin
            bad++;
            $display("FAIL post_edge_8 got a=%h b=%h dbg=%h expected deadbeef",
                     bus_a.ReadData1, bus_b.ReadData1, bus_a.DebugData);
        end
        total++;
        if (bus_a.WriteCount !== 16'd1 || bus_b.WriteCount !== 2'd1) begin
            bad++;
            $display("FAIL count_one got a=%0d b=%0d expected 1", bus_a.WriteCount, bus_b.WriteCount);
        end
    endtask

    task automatic test_zero_reg();
        @(negedge Clk);
        set_in(1'b1, 5'd0, 32'h12345678, 5'd0, 5'd0, 5'd0);
        #1;
        total++;
        if (bus_a.ReadData1 !== 32'd0 || bus_a.ReadData2 !== 32'd0) begin
            bad++;
            $display("FAIL zero_bypass got %h/%h expected 0", bus_a.ReadData1, bus_a.ReadData2);
        end
        @(negedge Clk);
        set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
        #1;
        total++;
        if (bus_a.ReadData1 !== 32'd0 || bus_a.DebugData !== 32'd0 ||
            bus_a.WriteCount !== 16'd1 || bus_b.WriteCount !== 2'd1) begin
            bad++;
            $display("FAIL zero_write got rd=%h dbg=%h cnt=%0d/%0d expected 0/0/1/1",
                     bus_a.ReadData1, bus_a.DebugData, bus_a.WriteCount, bus_b.WriteCount);
        end
    endtask

    task automatic test_bypass();
        @(negedge Clk);
        set_in(1'b1, 5'd9, 32'h1, 5'd0, 5'd0, 5'd9);
        @(negedge Clk);
        set_in(1'b1, 5'd9, 32'hA5A5A5A5, 5'd9, 5'd9, 5'd9);
        #1;
        total++;
        if (bus_a.ReadData1 !== 32'hA5A5A5A5 || bus_a.ReadData2 !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL bypass_ports got %h/%h expected a5a5a5a5", bus_a.ReadData1, bus_a.ReadData2);
        end
        total++;
        if (bus_a.DebugData !== 32'h1 || bus_b.ReadData1 !== 32'h1 || bus_b.ReadData2 !== 32'h1) begin
            bad++;
            $display("FAIL bypass_stored got dbg=%h b=%h/%h expected 1",
                     bus_a.DebugData, bus_b.ReadData1, bus_b.ReadData2);
        end
        @(posedge Clk);
        #1;
        total++;
        if (bus_a.DebugData !== 32'hA5A5A5A5 || bus_b.ReadData1 !== 32'hA5A5A5A5) begin
            bad++;
            $display("FAIL bypass_after got dbg=%h b=%h expected a5a5a5a5", bus_a.DebugData, bus_b.ReadData1);
        end
        @(negedge Clk);
        set_in(1'b0, 5'd0, 32'd0, 5'd0, 5'd0, 5'd0);
    endtask

    task automatic test_reset_midcycle();
        @(negedge Clk);
        set_in(1'b1, 5'd31, 32'hCAFE0000, 5'd0, 5'd0, 5'd0);
        @(negedge Clk);
        set_in(1'b1, 5'd5, 32'h77, 5'd5, 5'd31, 5'd31);
        #1;
        Reset = 1'b0;
        #1;
        total++;
        if (bus_a.ReadData1 !== 32'd0 || bus_a.ReadData2 !== 32'd0 || bus_a.DebugData !== 32'd0 ||
            bus_a.WriteCount !== 16'd0 || bus_b.ReadData2 !== 32'd0 || bus_b.WriteCount !== 2'd0) begin
            bad++;
            $display("FAIL async_reset got a=%h/%h/%h/%0d b=%h/%0d expected all 0",
                     bus_a.ReadData1, bus_a.ReadData2, bus_a.DebugData, bus_a.WriteCount,
                     bus_b.ReadData2, bus_b.WriteCount);
        end
        @(negedge Clk);
        set_in(1'b0, 5'd0, 32'd0, 5'd5, 5'd31, 5'd31);
        Reset = 1'b1;
        #1;
        total++;
        if (bus_a.ReadData1 !== 32'd0 || bus_a.ReadData2 !== 32'd0 || bus_a.DebugData !== 32'd0 ||
            bus_a.WriteCount !== 16'd0) begin
            bad++;
            $display("FAIL after_reset got %h/%h/%h/%0d expected 0",
                     bus_a.ReadData1, bus_a.ReadData2, bus_a.DebugData, bus_a.WriteCount);
        end
    endtask

    task automatic test_saturation();
        logic [1:0] seq [5];
        seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
        for (int i = 0; i < 5; i++) begin
            @(negedge Clk);
            set_in(1'b1, 5'(i + 1), $urandom, 5'(i + 1), 5'd0, 5'(i + 1));
            @(negedge Clk);
            set_in(1'b0, 5'd0, 32'd0, 5'(i + 1), 5'd0, 5'(i + 1));
            #1;
            total++;
            if (bus_b.WriteCount !== seq[i] || bus_a.WriteCount !== 16'(i + 1)) begin
                bad++;
                $display("FAIL saturate step=%0d got b=%0d a=%0d expected b=%0d a=%0d",
                         i, bus_b.WriteCount, bus_a.WriteCount, seq[i], i + 1);
            end
        end
    endtask

    task automatic test_random();
        logic        we;
        logic [4:0]  wa, r1, r2, dbg;
        logic [31:0] wd;
        for (int n = 0; n < 400; n++) begin
            @(negedge Clk);
            we  = ($urandom_range(0, 3) != 0);
            wa  = 5'($urandom_range(0, 31));
            wd  = $urandom;
            r1  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            r2  = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            dbg = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            set_in(we, wa, wd, r1, r2, dbg);
            #1;
            total++;
            if (bus_a.ReadData1 !== exp_rd(r1, 1'b1) || bus_a.ReadData2 !== exp_rd(r2, 1'b1) ||
                bus_a.DebugData !== exp_rd(dbg, 1'b0) || bus_a.WriteCount !== 16'(cnt_a)) begin
                bad++;
                $display("FAIL random_a n=%0d got %h/%h/%h/%0d expected %h/%h/%h/%0d", n,
                         bus_a.ReadData1, bus_a.ReadData2, bus_a.DebugData, bus_a.WriteCount,
                         exp_rd(r1, 1'b1), exp_rd(r2, 1'b1), exp_rd(dbg, 1'b0), cnt_a);
            end
            total++;
            if (bus_b.ReadData1 !== exp_rd(r1, 1'b0) || bus_b.ReadData2 !== exp_rd(r2, 1'b0) ||
                bus_b.DebugData !== exp_rd(dbg, 1'b0) || bus_b.WriteCount !== 2'(cnt_b)) begin
                bad++;
                $display("FAIL random_b n=%0d got %h/%h/%h/%0d expected %h/%h/%h/%0d", n,
                         bus_b.ReadData1, bus_b.ReadData2, bus_b.DebugData, bus_b.WriteCount,
                         exp_rd(r1, 1'b0), exp_rd(r2, 1'b0), exp_rd(dbg, 1'b0), cnt_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_reset_midcycle();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
